// File: rtl/btg_counter.sv
// rtl/btg_counter.sv - synchronous up/down binary counter with registered Gray-code output
//
// Purpose:
//   Keeps a WIDTH-bit binary count and presents the matching Gray code as a
//   registered output, so exactly one bit of gray changes per count step.
//   Supports parallel load, up/down stepping and a one-cycle wrap pulse.
//   Priority on each edge: rst > load > en > hold.
//
// Optional feature (macro BTG_SELFCHECK_EN):
//   Defined     - checker decodes the registered gray back to binary and
//                 compares it with bin every cycle; after an en step it also
//                 checks that gray moved by exactly one bit. Any mismatch sets
//                 the sticky gerr flag, which only rst clears.
//   Not defined - no checker; gerr is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   step the count by one this cycle
//   up        in   step direction when en=1 (1 = increment, 0 = decrement)
//   load      in   load bin from load_bin (overrides en)
//   load_bin  in   [WIDTH] binary value to load
//   bin       out  [WIDTH] registered binary count
//   gray      out  [WIDTH] registered Gray code of bin
//   tc        out  one-cycle registered wrap pulse
//   gerr      out  sticky self-check error

module btg_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             gerr
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_tc;

    // Next-state selection. tc only rises on a wrapping en step; load and
    // hold both drive it low.
    always_comb begin
        w_next_bin = r_bin;
        w_next_tc  = 1'b0;
        if (load) begin
            w_next_bin = load_bin;
        end else if (en) begin
            if (up) begin
                w_next_bin = r_bin + ONE;
                w_next_tc  = (r_bin == ALL_ONES);
            end else begin
                w_next_bin = r_bin - ONE;
                w_next_tc  = (r_bin == ZERO);
            end
        end
    end

    // Gray is encoded from the next binary value, not from r_bin, so both
    // registers update on the same edge and never disagree for a cycle.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= ZERO;
            r_gray <= ZERO;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_tc   <= w_next_tc;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign tc   = r_tc;

`ifdef BTG_SELFCHECK_EN
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_stepped;
    logic             r_gerr;

    logic [WIDTH-1:0] w_dec_bin;
    logic [WIDTH-1:0] w_gray_diff;
    logic             w_one_bit;
    logic             w_err;

    // Gray-to-binary via the XOR prefix chain from the MSB downward.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_dec_bin   = gray_to_bin(r_gray);
    assign w_gray_diff = r_gray ^ r_prev_gray;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_one_bit   = (w_gray_diff != ZERO) &&
                         ((w_gray_diff & (w_gray_diff - ONE)) == ZERO);
    assign w_err       = (w_dec_bin != r_bin) || (r_stepped && !w_one_bit);

    // r_stepped marks that the current r_gray came from an en step (not a
    // load or hold), so the single-bit-change rule applies this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_gray <= ZERO;
            r_stepped   <= 1'b0;
            r_gerr      <= 1'b0;
        end else begin
            r_prev_gray <= r_gray;
            r_stepped   <= en && !load;
            r_gerr      <= r_gerr || w_err;
        end
    end

    assign gerr = r_gerr;
`else
    assign gerr = 1'b0;
`endif

endmodule

// File: tb/tb_btg_counter.sv
// tb/tb_btg_counter.sv - directed self-checking bench for btg_counter

module tb_btg_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       gerr;

    int checks;
    int failures;

    btg_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .tc       (tc),
        .gerr     (gerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lb);
        rst = r; en = e; up = u; load = l; load_bin = lb;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] b,
                                input logic [3:0] g, input logic t);
        chk({tag, ".bin"},  bin,  b);
        chk({tag, ".gray"}, gray, g);
        chk({tag, ".tc"},   tc,   t);
    endtask

    logic [3:0] gray_tab [16];

    initial begin
        checks   = 0;
        failures = 0;
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                     4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110,
                     4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Reset for two cycles
        drive(1, 0, 0, 0, 4'h0);
        tick();
        tick();
        expect_state("reset", 4'h0, 4'h0, 1'b0);
        chk("reset.gerr", gerr, 0);

        // Up-count 17 steps, wrap on the 16th
        drive(0, 1, 1, 0, 4'h0);
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] kb;
            kb = 4'(k);
            tick();
            expect_state($sformatf("up%0d", k), kb, gray_tab[kb], (k == 16));
        end

        // Down-count wrap from reset
        drive(1, 0, 0, 0, 4'h0);
        tick();
        drive(0, 1, 0, 0, 4'h0);
        tick();
        expect_state("dnwrap", 4'hF, 4'b1000, 1'b1);
        tick();
        expect_state("dnnext", 4'hE, 4'b1001, 1'b0);

        // Load wins over a simultaneous en step
        drive(0, 1, 1, 1, 4'b1011);
        tick();
        expect_state("load", 4'b1011, 4'b1110, 1'b0);
        drive(0, 1, 1, 0, 4'h0);
        tick();
        expect_state("loadstep", 4'b1100, 4'b1010, 1'b0);

        // Load at all-ones with en up must not produce tc
        drive(0, 0, 0, 1, 4'hF);
        tick();
        drive(0, 1, 1, 1, 4'h3);
        tick();
        expect_state("loadnotc", 4'h3, 4'b0010, 1'b0);

        // Hold then direction change
        drive(0, 0, 0, 1, 4'b0101);
        tick();
        drive(0, 0, 1, 0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_state($sformatf("hold%0d", k), 4'b0101, 4'b0111, 1'b0);
        end
        drive(0, 1, 1, 0, 4'h0);
        tick();
        expect_state("dirup", 4'b0110, 4'b0101, 1'b0);
        drive(0, 1, 0, 0, 4'h0);
        tick();
        expect_state("dirdn", 4'b0101, 4'b0111, 1'b0);

        // Reset overrides simultaneous load and en
        drive(0, 0, 0, 1, 4'b1000);
        tick();
        drive(0, 1, 1, 0, 4'h0);
        tick();
        chk("pre_rst.bin", bin, 4'b1001);
        drive(1, 1, 1, 1, 4'b0110);
        tick();
        expect_state("midrst", 4'h0, 4'h0, 1'b0);
        chk("midrst.gerr", gerr, 0);

        // Self-check: clean 32-cycle count keeps gerr low
        drive(0, 1, 1, 0, 4'h0);
        for (int k = 0; k < 32; k++) begin
            tick();
            chk($sformatf("cnt32.gerr%0d", k), gerr, 0);
        end

`ifdef BTG_SELFCHECK_EN
        begin
            logic [3:0] g;
            g = dut.r_gray ^ 4'b0100;
            force dut.r_gray = g;
            tick();
            release dut.r_gray;
            chk("inj.gerr", gerr, 1);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("inj.sticky%0d", k), gerr, 1);
            end
            drive(1, 0, 0, 0, 4'h0);
            tick();
            chk("inj.clr", gerr, 0);
            drive(0, 1, 1, 0, 4'h0);
            tick();
            chk("inj.after", gerr, 0);
        end
`else
        drive(0, 1, 0, 0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("nochk.gerr%0d", k), gerr, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
